// File: rtl/mips_writeback_queue.sv
// Dual-lane in-order writeback queue feeding a two-port register file.
// It also forwards the youngest pending value for a queried register.
module mips_writeback_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_1,
    input  logic [4:0]  in_reg_1,
    input  logic [31:0] in_data_1,
    input  logic        in_valid_2,
    input  logic [4:0]  in_reg_2,
    input  logic [31:0] in_data_2,
    output logic        in_ready,
    input  logic        wb_stall,
    output logic [4:0]  write_reg_1,
    output logic [31:0] write_data_1,
    output logic        signal_reg_write_1,
    output logic [4:0]  write_reg_2,
    output logic [31:0] write_data_2,
    output logic        signal_reg_write_2,
    input  logic [4:0]  query_reg,
    output logic        query_hit,
    output logic [31:0] query_data,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    reg_mem_q  [DEPTH];
    logic [4:0]    reg_mem_d  [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   data_mem_d [DEPTH];

    logic          wr_en_1_q, wr_en_1_d, wr_en_2_q, wr_en_2_d;
    logic [4:0]    wr_reg_1_q, wr_reg_1_d, wr_reg_2_q, wr_reg_2_d;
    logic [31:0]   wr_data_1_q, wr_data_1_d, wr_data_2_q, wr_data_2_d;

    logic          accept_1_s, accept_2_s, pop_1_s, pop_2_s;
    logic [PW-1:0] second_ptr_s, lane2_ptr_s;
    logic          hit_s;
    logic [31:0]   hit_data_s;

    // Acceptance, pop selection and next-state computation
    always_comb begin
        in_ready     = (DEPTH_C - count_q) >= CW'(2);
        accept_1_s   = in_valid_1 && in_ready && (in_reg_1 != 5'd0);
        accept_2_s   = in_valid_2 && in_ready && (in_reg_2 != 5'd0);
        second_ptr_s = head_q + PW'(1);
        lane2_ptr_s  = accept_1_s ? (tail_q + PW'(1)) : tail_q;
        pop_1_s      = !wb_stall && (count_q >= CW'(1));
        // A same-register pair is split across cycles so the RF never sees two writes to one reg.
        pop_2_s      = pop_1_s && (count_q >= CW'(2)) &&
                       (reg_mem_q[second_ptr_s] != reg_mem_q[head_q]);

        for (int i = 0; i < DEPTH; i++) begin
            reg_mem_d[i]  = (accept_1_s && (tail_q == PW'(i)))      ? in_reg_1  :
                            (accept_2_s && (lane2_ptr_s == PW'(i))) ? in_reg_2  : reg_mem_q[i];
            data_mem_d[i] = (accept_1_s && (tail_q == PW'(i)))      ? in_data_1 :
                            (accept_2_s && (lane2_ptr_s == PW'(i))) ? in_data_2 : data_mem_q[i];
        end

        head_d  = head_q + PW'(pop_1_s) + PW'(pop_2_s);
        tail_d  = tail_q + PW'(accept_1_s) + PW'(accept_2_s);
        count_d = count_q + CW'(accept_1_s) + CW'(accept_2_s) - CW'(pop_1_s) - CW'(pop_2_s);

        wr_en_1_d   = pop_1_s;
        wr_reg_1_d  = pop_1_s ? reg_mem_q[head_q]          : 5'd0;
        wr_data_1_d = pop_1_s ? data_mem_q[head_q]         : 32'd0;
        wr_en_2_d   = pop_2_s;
        wr_reg_2_d  = pop_2_s ? reg_mem_q[second_ptr_s]    : 5'd0;
        wr_data_2_d = pop_2_s ? data_mem_q[second_ptr_s]   : 32'd0;
    end

    // Forwarding lookup: later matches override, scanning oldest to youngest
    always_comb begin
        hit_s      = wr_en_1_q && (wr_reg_1_q == query_reg);
        hit_data_s = hit_s ? wr_data_1_q : 32'd0;
        hit_data_s = (wr_en_2_q && (wr_reg_2_q == query_reg)) ? wr_data_2_q : hit_data_s;
        hit_s      = hit_s || (wr_en_2_q && (wr_reg_2_q == query_reg));
        for (int i = 0; i < DEPTH; i++) begin
            hit_data_s = ((CW'(i) < count_q) && (reg_mem_q[head_q + PW'(i)] == query_reg)) ?
                         data_mem_q[head_q + PW'(i)] : hit_data_s;
            hit_s      = hit_s || ((CW'(i) < count_q) && (reg_mem_q[head_q + PW'(i)] == query_reg));
        end
        query_hit  = hit_s && (query_reg != 5'd0);
        query_data = query_hit ? hit_data_s : 32'd0;
        empty      = (count_q == CW'(0)) && !wr_en_1_q && !wr_en_2_q;
    end

    // Control state and registered write ports
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            wr_en_1_q   <= 1'b0;
            wr_reg_1_q  <= 5'd0;
            wr_data_1_q <= 32'd0;
            wr_en_2_q   <= 1'b0;
            wr_reg_2_q  <= 5'd0;
            wr_data_2_q <= 32'd0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            wr_en_1_q   <= wr_en_1_d;
            wr_reg_1_q  <= wr_reg_1_d;
            wr_data_1_q <= wr_data_1_d;
            wr_en_2_q   <= wr_en_2_d;
            wr_reg_2_q  <= wr_reg_2_d;
            wr_data_2_q <= wr_data_2_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            reg_mem_q[i]  <= reg_mem_d[i];
            data_mem_q[i] <= data_mem_d[i];
        end
    end

    assign signal_reg_write_1 = wr_en_1_q;
    assign write_reg_1        = wr_reg_1_q;
    assign write_data_1       = wr_data_1_q;
    assign signal_reg_write_2 = wr_en_2_q;
    assign write_reg_2        = wr_reg_2_q;
    assign write_data_2       = wr_data_2_q;

endmodule

// File: tb/tb_mips_writeback_queue.sv
// Directed and randomised checks of mips_writeback_queue against a queue-based model.
module tb_mips_writeback_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v1 = 1'b0, v2 = 1'b0, stall = 1'b0;
    logic [4:0]  r1 = 5'd0, r2 = 5'd0, qr = 5'd0;
    logic [31:0] d1 = 32'd0, d2 = 32'd0;

    logic        in_ready, we1, we2, query_hit, empty;
    logic [4:0]  wr1, wr2;
    logic [31:0] wd1, wd2, query_data;

    int vecs = 0;
    int miss = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        e_we1 = 1'b0, e_we2 = 1'b0;
    logic [4:0]  e_r1 = 5'd0, e_r2 = 5'd0;
    logic [31:0] e_d1 = 32'd0, e_d2 = 32'd0;

    mips_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid_1(v1), .in_reg_1(r1), .in_data_1(d1),
        .in_valid_2(v2), .in_reg_2(r2), .in_data_2(d2),
        .in_ready(in_ready), .wb_stall(stall),
        .write_reg_1(wr1), .write_data_1(wd1), .signal_reg_write_1(we1),
        .write_reg_2(wr2), .write_data_2(wd2), .signal_reg_write_2(we2),
        .query_reg(qr), .query_hit(query_hit), .query_data(query_data),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Golden model: advance one clock edge using the inputs present at that edge
    task automatic model_step();
        int n;
        bit rdy;
        n = mq.size();
        rdy = (DEPTH - n) >= 2;
        e_we1 = 1'b0; e_r1 = 5'd0; e_d1 = 32'd0;
        e_we2 = 1'b0; e_r2 = 5'd0; e_d2 = 32'd0;
        if (rst) begin
            mq.delete();
        end else begin
            if (!stall && n >= 1) begin
                e_we1 = 1'b1; e_r1 = mq[0].r; e_d1 = mq[0].d;
                if (n >= 2 && mq[1].r != mq[0].r) begin
                    e_we2 = 1'b1; e_r2 = mq[1].r; e_d2 = mq[1].d;
                    void'(mq.pop_front());
                end
                void'(mq.pop_front());
            end
            if (rdy && v1 && r1 != 5'd0) mq.push_back('{r: r1, d: d1});
            if (rdy && v2 && r2 != 5'd0) mq.push_back('{r: r2, d: d2});
        end
    endtask

    task automatic model_query(output logic h, output logic [31:0] d);
        h = 1'b0;
        d = 32'd0;
        if (qr != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0 && !h; i--) begin
                if (mq[i].r == qr) begin h = 1'b1; d = mq[i].d; end
            end
            if (!h && e_we2 && e_r2 == qr) begin h = 1'b1; d = e_d2; end
            if (!h && e_we1 && e_r1 == qr) begin h = 1'b1; d = e_d1; end
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic        mh;
        logic [31:0] md;
        if (chk_en) begin
            model_query(mh, md);
            chk("in_ready", 32'(in_ready), 32'((DEPTH - mq.size()) >= 2));
            chk("empty", 32'(empty), 32'(mq.size() == 0 && !e_we1 && !e_we2));
            chk("we1", 32'(we1), 32'(e_we1));
            chk("wr1", 32'(wr1), 32'(e_r1));
            chk("wd1", wd1, e_d1);
            chk("we2", 32'(we2), 32'(e_we2));
            chk("wr2", 32'(wr2), 32'(e_r2));
            chk("wd2", wd2, e_d2);
            chk("query_hit", 32'(query_hit), 32'(mh));
            chk("query_data", query_data, md);
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic push(input logic a, input logic [4:0] ra, input logic [31:0] da,
                        input logic b, input logic [4:0] rb, input logic [31:0] db);
        v1 = a; r1 = ra; d1 = da;
        v2 = b; r2 = rb; d2 = db;
        step();
        v1 = 1'b0; v2 = 1'b0;
    endtask

    task automatic idle();
        push(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        qr = 5'd5;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst hit", 32'(query_hit), 32'd0);
        chk("rst qdata", query_data, 32'd0);

        // Single push on lane 1
        push(1'b1, 5'd5, 32'hAAAA0001, 1'b0, 5'd0, 32'd0);
        idle();
        chk("single we1", 32'(we1), 32'd1);
        chk("single wr1", 32'(wr1), 32'd5);
        chk("single wd1", wd1, 32'hAAAA0001);
        chk("single we2", 32'(we2), 32'd0);
        idle();
        chk("single empty", 32'(empty), 32'd1);

        // Same-register pair is serialised
        qr = 5'd3;
        push(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2);
        chk("pair q0", query_data, 32'h2);
        idle();
        chk("pair A we1", 32'(we1), 32'd1);
        chk("pair A wd1", wd1, 32'h1);
        chk("pair A we2", 32'(we2), 32'd0);
        chk("pair A q", query_data, 32'h2);
        idle();
        chk("pair B wd1", wd1, 32'h2);
        chk("pair B we2", 32'(we2), 32'd0);
        chk("pair B q", query_data, 32'h2);
        idle();

        // Register zero is discarded
        qr = 5'd0;
        push(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd7, 32'h7);
        chk("r0 hit", 32'(query_hit), 32'd0);
        idle();
        chk("r0 wr1", 32'(wr1), 32'd7);
        chk("r0 we2", 32'(we2), 32'd0);
        idle();

        // Fill under stall to 7, then to 8
        stall = 1'b1;
        push(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'd0);
        push(1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33);
        push(1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55);
        push(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77);
        chk("fill7 ready", 32'(in_ready), 32'd0);
        push(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
        chk("fill7 hold", 32'(in_ready), 32'd0);
        stall = 1'b0;
        idle();
        chk("drain wr1", 32'(wr1), 32'd1);
        chk("drain wr2", 32'(wr2), 32'd2);
        repeat (4) idle();
        stall = 1'b1;
        for (int i = 0; i < 4; i++)
            push(1'b1, 5'(2 * i + 10), 32'(i), 1'b1, 5'(2 * i + 11), 32'(i + 100));
        chk("fill8 ready", 32'(in_ready), 32'd0);
        push(1'b1, 5'd20, 32'hDEAD, 1'b1, 5'd21, 32'hBEEF);
        stall = 1'b0;
        repeat (5) idle();

        // Reset in mid-operation at count 5
        stall = 1'b1;
        push(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'd0);
        push(1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 32'h3);
        push(1'b1, 5'd4, 32'h4, 1'b1, 5'd5, 32'h5);
        rst = 1'b1;
        push(1'b1, 5'd6, 32'h6, 1'b1, 5'd7, 32'h7);
        rst = 1'b0;
        stall = 1'b0;
        chk("mrst we1", 32'(we1), 32'd0);
        chk("mrst we2", 32'(we2), 32'd0);
        chk("mrst empty", 32'(empty), 32'd1);
        chk("mrst ready", 32'(in_ready), 32'd1);
        idle();

        // Random pairs with random stalls across pointer wrap
        for (int i = 0; i < 20; i++) begin
            stall = ($urandom_range(0, 2) == 0);
            qr = 5'($urandom_range(0, 7));
            push(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
        end
        stall = 1'b0;
        repeat (12) begin
            qr = 5'($urandom_range(0, 7));
            idle();
        end
        chk("final empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/mips_writeback_queue.md
MIPS_WRITEBACK_QUEUE -- requirements
Module: mips_writeback_queue

Interface
REQ-001 The module SHALL have one parameter: DEPTH, default 8, queue entry count (power of two, minimum 4).
REQ-002 The module SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid_1, in_valid_2  input  1 each  result offered on enqueue lane 1/2; lane 1 is older than lane 2.
REQ-006 in_reg_1, in_reg_2  input  5 each  destination register of lane 1/2.
REQ-007 in_data_1, in_data_2  input  32 each  result data of lane 1/2.
REQ-008 in_ready  output  1  both lanes are accepted this cycle.
REQ-009 wb_stall  input  1  when high, no entries are popped this cycle.
REQ-010 write_reg_1, write_reg_2  output  5 each  register-file write addresses (registered).
REQ-011 write_data_1, write_data_2  output  32 each  register-file write data (registered).
REQ-012 signal_reg_write_1, signal_reg_write_2  output  1 each  register-file write enables (registered).
REQ-013 query_reg  input  5  register looked up for pending writes.
REQ-014 query_hit, query_data  output  1 / 32  youngest pending value for query_reg (combinational).
REQ-015 empty  output  1  queue count is 0 and both write enables are low.

Function
REQ-016 in_ready SHALL be high iff (DEPTH - count) >= 2, using count before this cycle's pop; a pop never frees space in the same cycle.
REQ-017 A lane SHALL be accepted iff in_valid_x and in_ready are both high at the rising edge.
REQ-018 An accepted lane with reg 0 SHALL be discarded and not stored.
REQ-019 When both lanes are stored in one cycle, lane 1 SHALL occupy the older slot.
REQ-020 Pop selection SHALL occur when wb_stall is low and count >= 1; the head entry SHALL be popped onto port 1.
REQ-021 The second-oldest entry SHALL also be popped onto port 2 iff count >= 2 and its reg differs from the head reg; otherwise only one entry SHALL be popped.
REQ-022 The write outputs SHALL be registered: entries popped at edge N drive the port-1/2 outputs with their enables high during cycle N..N+1.
REQ-023 An unused port, and both ports when stalled or empty, SHALL drive enable 0 with reg and data 0.
REQ-024 Minimum latency SHALL be: data enqueued at edge N is popped at edge N+1 and written by the register file at edge N+2.
REQ-025 Push and pop in the same cycle SHALL both take effect; count_next = count + pushed - popped; pointers SHALL wrap modulo DEPTH.
REQ-026 query_hit SHALL be high iff query_reg != 0 and it matches a stored entry or an output port with its enable high.
REQ-027 query_data SHALL come from the youngest match, with priority queue entries (youngest first) > port 2 > port 1.
REQ-028 No entry SHALL ever be dropped, duplicated, or reordered among same-register writes.

Reset
REQ-029 While rst is high at a rising edge, count, pointers, and all write outputs SHALL be cleared to 0, and any lane input that cycle SHALL be ignored.
REQ-030 After reset: in_ready=1, empty=1, query_hit=0, query_data=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries, with no write enables high the following cycle.

Verification
REQ-032 Single push: lane 1 only (r5, 0xAAAA0001) at edge 0 -> at edge 1, signal_reg_write_1=1, write_reg_1=5, write_data_1=0xAAAA0001, signal_reg_write_2=0; empty=1 after edge 2.
REQ-033 Same-register pair: lane 1 (r3, 0x1), lane 2 (r3, 0x2) -> cycle A writes only r3=0x1 on port 1; cycle B writes r3=0x2 on port 1; query r3 returns 0x2 throughout.
REQ-034 Fill/stall: wb_stall=1 while pushing pairs -> in_ready=0 at count 7 and 8; count never exceeds 8; releasing the stall drains 2 entries per cycle in order.
REQ-035 Zero register: lane 1 (r0, 0xFFFF), lane 2 (r7, 0x7) -> only r7 is written; query r0 gives hit=0.
REQ-036 Wrap: 20 random pairs with random stalls -> the write sequence matches the golden in-order model across pointer wrap.
REQ-037 Mid-op reset: rst at count=5 -> next cycle count=0, all enables 0, empty=1.
